diagnosis_snapshot_decoder: RTL and testbench

- Receiving end of the diagnosis system's debug-NoC snapshot output.
- Consumes 16-bit lisnoc16 flits carrying snapshot packets (event header, then tagged 32-bit GPR/stack words) and reassembles them into a record stream for the host-side trace buffer / USB bridge.
- Sits on the host side of the debug NoC router, one instance per diagnosis endpoint group.
- Drops malformed packets and counts them.

---
 rtl/diagnosis_pkg.sv | 44 ++++
 rtl/diagnosis_snapshot_decoder.sv | 171 +++++++++++++++++
 tb/tb_diagnosis_snapshot_decoder.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/diagnosis_pkg.sv
// rtl/diagnosis_pkg.sv - shared flit constants, FSM states and record type for the snapshot decoder
package diagnosis_pkg;

    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;
    localparam logic [1:0] FLIT_SINGLE  = 2'b11;

    localparam logic [2:0] DIAG_CLASS_SNAPSHOT = 3'b011;

    localparam int HDR_CLASS_MSB = 10;
    localparam int HDR_CLASS_LSB = 8;
    localparam int TAG_TYPE_MSB  = 15;
    localparam int TAG_TYPE_LSB  = 13;
    localparam int TAG_INDEX_MSB = 12;
    localparam int TAG_INDEX_LSB = 8;

    localparam int REC_EV_ID_WIDTH = 12;
    localparam int REC_TIME_WIDTH  = 32;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SRC,
        S_EVID,
        S_TSHI,
        S_TSLO,
        S_TAG,
        S_DHI,
        S_DLO,
        S_DROP
    } diag_state_e;

    typedef struct packed {
        logic                       kind;
        logic [15:0]                core_id;
        logic [REC_EV_ID_WIDTH-1:0] ev_id;
        logic [REC_TIME_WIDTH-1:0]  ts;
        logic [2:0]                 dtype;
        logic [4:0]                 index;
        logic [31:0]                data;
        logic                       last;
    } snapshot_record_t;

endpackage

// File: rtl/diagnosis_snapshot_decoder.sv
// rtl/diagnosis_snapshot_decoder.sv - reassembles debug-NoC snapshot packets into header/data records
module diagnosis_snapshot_decoder
    import diagnosis_pkg::*;
#(
    parameter int          DBG_NOC_DATA_WIDTH      = 16,
    parameter int          DBG_NOC_FLIT_TYPE_WIDTH = 2,
    parameter int          DBG_NOC_VCHANNELS       = 1,
    parameter int          EV_ID_WIDTH             = REC_EV_ID_WIDTH,
    parameter int          TIMESTAMP_WIDTH         = REC_TIME_WIDTH,
    parameter logic [2:0]  DIAG_CLASS              = DIAG_CLASS_SNAPSHOT,
    parameter int          ERRCNT_WIDTH            = 8
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic [DBG_NOC_FLIT_TYPE_WIDTH+DBG_NOC_DATA_WIDTH-1:0] dbgnoc_in_flit,
    input  logic [DBG_NOC_VCHANNELS-1:0]                          dbgnoc_in_valid,
    output logic [DBG_NOC_VCHANNELS-1:0]                          dbgnoc_in_ready,
    output logic                                                  rec_valid,
    input  logic                                                  rec_ready,
    output logic                                                  rec_kind,
    output logic [15:0]                                           rec_core_id,
    output logic [EV_ID_WIDTH-1:0]                                rec_ev_id,
    output logic [TIMESTAMP_WIDTH-1:0]                            rec_time,
    output logic [2:0]                                            rec_type,
    output logic [4:0]                                            rec_index,
    output logic [31:0]                                           rec_data,
    output logic                                                  rec_last,
    output logic                                                  err_pulse,
    output logic [ERRCNT_WIDTH-1:0]                               err_count
);

    logic [DBG_NOC_FLIT_TYPE_WIDTH-1:0] flit_type;
    logic [DBG_NOC_DATA_WIDTH-1:0]      flit_data;
    logic [2:0]                         flit_class;
    logic                               flit_ready;
    logic                               flit_xfer;

    diag_state_e      state_q, state_d;
    snapshot_record_t rec_q, rec_d;

    logic [15:0]                core_q;
    logic [EV_ID_WIDTH-1:0]     ev_q;
    logic [15:0]                tshi_q;
    logic [TIMESTAMP_WIDTH-1:0] ts_q;
    logic [2:0]                 tag_type_q;
    logic [4:0]                 tag_index_q;
    logic [15:0]                dhi_q;

    logic err_ev, emit, emit_data, emit_last;
    logic ld_core, ld_ev, ld_tshi, ld_tag, ld_dhi;

    assign flit_type  = dbgnoc_in_flit[DBG_NOC_FLIT_TYPE_WIDTH+DBG_NOC_DATA_WIDTH-1:DBG_NOC_DATA_WIDTH];
    assign flit_data  = dbgnoc_in_flit[DBG_NOC_DATA_WIDTH-1:0];
    assign flit_class = flit_data[HDR_CLASS_MSB:HDR_CLASS_LSB];

    // Backpressure is purely a function of the output slot, independent of FSM state.
    assign flit_ready = !rec_valid || rec_ready;
    assign flit_xfer  = dbgnoc_in_valid[0] && flit_ready;

    always_comb begin
        dbgnoc_in_ready    = '0;
        dbgnoc_in_ready[0] = flit_ready;
    end

    always_comb begin
        state_d   = state_q;
        err_ev    = 1'b0;
        emit      = 1'b0;
        emit_data = 1'b0;
        emit_last = 1'b0;
        ld_core   = 1'b0;
        ld_ev     = 1'b0;
        ld_tshi   = 1'b0;
        ld_tag    = 1'b0;
        ld_dhi    = 1'b0;
        if (flit_xfer) begin
            case (flit_type)
                FLIT_HEADER: begin
                    err_ev  = (state_q != S_IDLE) && (state_q != S_DROP);
                    state_d = (flit_class == DIAG_CLASS) ? S_SRC : S_DROP;
                end
                FLIT_SINGLE: begin
                    state_d = S_IDLE;
                    if (state_q == S_IDLE) err_ev = (flit_class == DIAG_CLASS);
                    else                   err_ev = (state_q != S_DROP);
                end
                FLIT_PAYLOAD: begin
                    case (state_q)
                        S_IDLE: err_ev = 1'b1;
                        S_SRC:  begin ld_core = 1'b1; state_d = S_EVID; end
                        S_EVID: begin ld_ev   = 1'b1; state_d = S_TSHI; end
                        S_TSHI: begin ld_tshi = 1'b1; state_d = S_TSLO; end
                        S_TSLO: begin emit    = 1'b1; state_d = S_TAG;  end
                        S_TAG:  begin ld_tag  = 1'b1; state_d = S_DHI;  end
                        S_DHI:  begin ld_dhi  = 1'b1; state_d = S_DLO;  end
                        S_DLO:  begin emit = 1'b1; emit_data = 1'b1; state_d = S_TAG; end
                        default: ;
                    endcase
                end
                default: begin
                    state_d = S_IDLE;
                    case (state_q)
                        S_TSLO: begin emit = 1'b1; emit_last = 1'b1; end
                        S_DLO:  begin emit = 1'b1; emit_data = 1'b1; emit_last = 1'b1; end
                        S_DROP: ;
                        default: err_ev = 1'b1;
                    endcase
                end
            endcase
        end
    end

    // Data records reuse the timestamp captured when the header record was emitted.
    always_comb begin
        rec_d         = '0;
        rec_d.kind    = emit_data;
        rec_d.core_id = core_q;
        rec_d.ev_id   = ev_q;
        rec_d.ts      = emit_data ? ts_q : {tshi_q, flit_data};
        rec_d.dtype   = emit_data ? tag_type_q : 3'd0;
        rec_d.index   = emit_data ? tag_index_q : 5'd0;
        rec_d.data    = emit_data ? {dhi_q, flit_data} : 32'd0;
        rec_d.last    = emit_last;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rec_q       <= '0;
            rec_valid   <= 1'b0;
            core_q      <= '0;
            ev_q        <= '0;
            tshi_q      <= '0;
            ts_q        <= '0;
            tag_type_q  <= '0;
            tag_index_q <= '0;
            dhi_q       <= '0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
        end else begin
            state_q   <= state_d;
            err_pulse <= err_ev;
            if (err_ev && (err_count != '1)) err_count <= err_count + 1'b1;
            if (ld_core) core_q <= flit_data;
            if (ld_ev)   ev_q   <= flit_data[EV_ID_WIDTH-1:0];
            if (ld_tshi) tshi_q <= flit_data;
            if (ld_tag) begin
                tag_type_q  <= flit_data[TAG_TYPE_MSB:TAG_TYPE_LSB];
                tag_index_q <= flit_data[TAG_INDEX_MSB:TAG_INDEX_LSB];
            end
            if (ld_dhi) dhi_q <= flit_data;
            if (emit && !emit_data) ts_q <= {tshi_q, flit_data};
            if (emit) begin
                rec_q     <= rec_d;
                rec_valid <= 1'b1;
            end else if (rec_ready) begin
                rec_valid <= 1'b0;
            end
        end
    end

    assign rec_kind    = rec_q.kind;
    assign rec_core_id = rec_q.core_id;
    assign rec_ev_id   = rec_q.ev_id;
    assign rec_time    = rec_q.ts;
    assign rec_type    = rec_q.dtype;
    assign rec_index   = rec_q.index;
    assign rec_data    = rec_q.data;
    assign rec_last    = rec_q.last;

endmodule

// File: tb/tb_diagnosis_snapshot_decoder.sv
// tb/tb_diagnosis_snapshot_decoder.sv - directed and randomized bench for diagnosis_snapshot_decoder
module tb_diagnosis_snapshot_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] dbgnoc_in_flit;
    logic [0:0]  dbgnoc_in_valid;
    logic [0:0]  dbgnoc_in_ready;
    logic        rec_valid, rec_ready, rec_kind, rec_last, err_pulse;
    logic [15:0] rec_core_id;
    logic [11:0] rec_ev_id;
    logic [31:0] rec_time, rec_data;
    logic [2:0]  rec_type;
    logic [4:0]  rec_index;
    logic [7:0]  err_count;
    logic [101:0] rec_vec;

    always #5 clk = ~clk;

    diagnosis_snapshot_decoder dut (
        .clk(clk), .rst(rst),
        .dbgnoc_in_flit(dbgnoc_in_flit), .dbgnoc_in_valid(dbgnoc_in_valid),
        .dbgnoc_in_ready(dbgnoc_in_ready),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind),
        .rec_core_id(rec_core_id), .rec_ev_id(rec_ev_id), .rec_time(rec_time),
        .rec_type(rec_type), .rec_index(rec_index), .rec_data(rec_data),
        .rec_last(rec_last), .err_pulse(err_pulse), .err_count(err_count)
    );

    assign rec_vec = {rec_kind, rec_core_id, rec_ev_id, rec_time, rec_type, rec_index, rec_data, rec_last};

    int n_assert = 0;
    int n_fail = 0;
    int err_total = 0;
    int exp_errs = 0;
    logic [17:0]  flit_q[$];
    logic [101:0] exp_q[$];

    task automatic check(input string tag, input logic [101:0] obs, input logic [101:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [101:0] mk_rec(input logic kind, input logic [15:0] core,
                                            input logic [11:0] ev, input logic [31:0] ts,
                                            input logic [2:0] ty, input logic [4:0] idx,
                                            input logic [31:0] d, input logic last);
        return {kind, core, ev, ts, ty, idx, d, last};
    endfunction

    function automatic logic [17:0] ctl_flit(input logic [1:0] ft, input logic [2:0] cls);
        logic [15:0] r;
        r = 16'($urandom);
        return {ft, r[15:11], cls, r[7:0]};
    endfunction

    function automatic logic [2:0] foreign_cls();
        int c;
        c = $urandom_range(0, 6);
        if (c >= 3) c++;
        return 3'(c);
    endfunction

    task automatic add_err();
        exp_errs++;
        err_total++;
    endtask

    task automatic pf(input logic [1:0] ft, input logic [15:0] d);
        flit_q.push_back({ft, d});
    endtask

    // Packet-level model: k content flits after the header; the last one is a LAST flit
    // when by_last, otherwise the packet is cut off by whatever flit follows.
    task automatic diag_packet(input int k, input bit by_last);
        logic [15:0] c[$];
        logic [15:0] w, tg, c1;
        flit_q.push_back(ctl_flit(2'b01, 3'b011));
        for (int i = 0; i < k; i++) begin
            w = 16'($urandom);
            c.push_back(w);
            pf((by_last && i == k - 1) ? 2'b10 : 2'b00, w);
        end
        if (k >= 4) begin
            c1 = c[1];
            exp_q.push_back(mk_rec(1'b0, c[0], c1[11:0], {c[2], c[3]}, 3'd0, 5'd0, 32'd0,
                                   by_last && k == 4));
            for (int j = 0; 7 + 3 * j <= k; j++) begin
                tg = c[4 + 3 * j];
                exp_q.push_back(mk_rec(1'b1, c[0], c1[11:0], {c[2], c[3]}, tg[15:13], tg[12:8],
                                       {c[5 + 3 * j], c[6 + 3 * j]}, by_last && k == 7 + 3 * j));
            end
        end
        if (!by_last || k < 4 || ((k - 4) % 3) != 0) add_err();
    endtask

    task automatic gen_random(input int n);
        int  sel;
        bit  pending;
        pending = 0;
        for (int i = 0; i < n; i++) begin
            sel = pending ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
            pending = 0;
            case (sel)
                0, 5: diag_packet(int'($urandom_range(1, 13)), 1'b1);
                1: begin
                    diag_packet(int'($urandom_range(0, 9)), 1'b0);
                    pf(2'b11, 16'($urandom));
                end
                2: begin
                    diag_packet(int'($urandom_range(0, 9)), 1'b0);
                    pending = 1;
                end
                3: begin
                    flit_q.push_back(ctl_flit(2'b01, foreign_cls()));
                    repeat ($urandom_range(0, 4)) pf(2'b00, 16'($urandom));
                    pf(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11, 16'($urandom));
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: begin pf(2'b00, 16'($urandom)); add_err(); end
                        1: begin pf(2'b10, 16'($urandom)); add_err(); end
                        2: begin flit_q.push_back(ctl_flit(2'b11, 3'b011)); add_err(); end
                        default: flit_q.push_back(ctl_flit(2'b11, foreign_cls()));
                    endcase
                end
            endcase
        end
        if (pending) diag_packet(4, 1'b1);
    endtask

    task automatic run_stream(input int ready_pct, input int valid_pct, input int hold);
        int budget, drain, pulses, hold_left;
        logic held;
        logic [101:0] held_vec;
        budget = flit_q.size() * 30 + 300;
        drain = 0; pulses = 0; hold_left = hold; held = 0; held_vec = '0;
        while (drain < 4 && budget > 0) begin
            @(negedge clk);
            if (err_pulse) pulses++;
            if (held) check("hold_stable", rec_vec, held_vec);
            dbgnoc_in_valid[0] = (flit_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
            dbgnoc_in_flit = dbgnoc_in_valid[0] ? flit_q[0] : 18'h0;
            if (rec_valid && hold_left > 0) begin
                rec_ready = 1'b0;
                hold_left--;
            end else begin
                rec_ready = ($urandom_range(0, 99) < ready_pct);
            end
            #1;
            if (rec_valid && !rec_ready) check("backpressure_ready", dbgnoc_in_ready, 0);
            if (rec_valid && rec_ready) begin
                if (exp_q.size() == 0) check("record_extra", exp_q.size(), 1);
                else check("record", rec_vec, exp_q.pop_front());
            end
            held = rec_valid && !rec_ready;
            held_vec = rec_vec;
            if (dbgnoc_in_valid[0] && dbgnoc_in_ready[0]) void'(flit_q.pop_front());
            drain = (flit_q.size() == 0 && exp_q.size() == 0) ? drain + 1 : 0;
            budget--;
        end
        check("stream_done", flit_q.size() + exp_q.size(), 0);
        check("err_pulses", pulses, exp_errs);
        check("err_count", err_count, (err_total > 255) ? 255 : err_total);
        flit_q.delete();
        exp_q.delete();
        exp_errs = 0;
    endtask

    task automatic push_basic_packet();
        flit_q.push_back(ctl_flit(2'b01, 3'b011));
        pf(2'b00, 16'h0005); pf(2'b00, 16'h0123); pf(2'b00, 16'hDEAD); pf(2'b10, 16'hBEEF);
        exp_q.push_back(mk_rec(1'b0, 16'h5, 12'h123, 32'hDEADBEEF, 3'd0, 5'd0, 32'd0, 1'b1));
    endtask

    task automatic push_two_group_packet();
        flit_q.push_back(ctl_flit(2'b01, 3'b011));
        pf(2'b00, 16'h0007); pf(2'b00, 16'h0456); pf(2'b00, 16'h0001); pf(2'b00, 16'h0002);
        pf(2'b00, 16'h2300); pf(2'b00, 16'h1234); pf(2'b00, 16'h5678);
        pf(2'b00, 16'h4500); pf(2'b00, 16'hAAAA); pf(2'b10, 16'h5555);
        exp_q.push_back(mk_rec(1'b0, 16'h7, 12'h456, 32'h00010002, 3'd0, 5'd0, 32'd0, 1'b0));
        exp_q.push_back(mk_rec(1'b1, 16'h7, 12'h456, 32'h00010002, 3'd1, 5'd3, 32'h12345678, 1'b0));
        exp_q.push_back(mk_rec(1'b1, 16'h7, 12'h456, 32'h00010002, 3'd2, 5'd5, 32'hAAAA5555, 1'b1));
    endtask

    initial begin
        int budget;
        rst = 1'b1;
        dbgnoc_in_flit = '0;
        dbgnoc_in_valid = '0;
        rec_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_rec", rec_vec, '0);
        check("reset_valid", rec_valid, 0);
        check("reset_in_ready", dbgnoc_in_ready, 1);
        check("reset_err_pulse", err_pulse, 0);
        check("reset_err_count", err_count, 0);

        push_basic_packet();
        run_stream(100, 100, 0);

        push_two_group_packet();
        run_stream(100, 100, 0);

        push_two_group_packet();
        run_stream(100, 100, 6);
        push_two_group_packet();
        run_stream(40, 70, 0);

        // Truncated on the DHI word, then a clean packet.
        flit_q.push_back(ctl_flit(2'b01, 3'b011));
        pf(2'b00, 16'h0009); pf(2'b00, 16'h000A); pf(2'b00, 16'h1000); pf(2'b00, 16'h2000);
        pf(2'b00, 16'h2300); pf(2'b10, 16'h1234);
        exp_q.push_back(mk_rec(1'b0, 16'h9, 12'h00A, 32'h10002000, 3'd0, 5'd0, 32'd0, 1'b0));
        add_err();
        push_basic_packet();
        run_stream(100, 100, 0);

        // Foreign class dropped silently; DIAG packet aborted in TSHI by a new header.
        flit_q.push_back(ctl_flit(2'b01, 3'b101));
        pf(2'b00, 16'h1111); pf(2'b00, 16'h2222); pf(2'b10, 16'h3333);
        flit_q.push_back(ctl_flit(2'b01, 3'b011));
        pf(2'b00, 16'h0011); pf(2'b00, 16'h0022);
        flit_q.push_back(ctl_flit(2'b01, 3'b011));
        add_err();
        pf(2'b00, 16'h0033); pf(2'b00, 16'h0044); pf(2'b00, 16'h5555); pf(2'b10, 16'h6666);
        exp_q.push_back(mk_rec(1'b0, 16'h33, 12'h044, 32'h55556666, 3'd0, 5'd0, 32'd0, 1'b1));
        run_stream(100, 100, 0);

        gen_random(40);
        run_stream(70, 80, 0);
        gen_random(40);
        run_stream(50, 60, 0);

        for (int i = 0; i < 300; i++) begin
            pf(2'b00, 16'($urandom));
            add_err();
        end
        run_stream(100, 100, 0);

        // Leave a data record pending, then assert reset between clock edges.
        flit_q.push_back(ctl_flit(2'b01, 3'b011));
        pf(2'b00, 16'h0042); pf(2'b00, 16'h0777); pf(2'b00, 16'h1111); pf(2'b00, 16'h2222);
        pf(2'b00, 16'h2300); pf(2'b00, 16'hCAFE); pf(2'b00, 16'hF00D);
        budget = 100;
        while (flit_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            rec_ready = 1'b1;
            dbgnoc_in_valid[0] = 1'b1;
            dbgnoc_in_flit = flit_q[0];
            #1;
            if (dbgnoc_in_ready[0]) void'(flit_q.pop_front());
            budget--;
        end
        @(negedge clk);
        rec_ready = 1'b0;
        dbgnoc_in_valid = '0;
        dbgnoc_in_flit = '0;
        #1;
        check("pre_reset_valid", rec_valid, 1);
        check("pre_reset_rec", rec_vec,
              mk_rec(1'b1, 16'h42, 12'h777, 32'h11112222, 3'd1, 5'd3, 32'hCAFEF00D, 1'b0));
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_rec", rec_vec, '0);
        check("async_reset_valid", rec_valid, 0);
        check("async_reset_in_ready", dbgnoc_in_ready, 1);
        check("async_reset_err_count", err_count, 0);
        @(negedge clk);
        rst = 1'b0;
        flit_q.delete();
        exp_q.delete();
        err_total = 0;
        exp_errs = 0;
        push_basic_packet();
        run_stream(100, 100, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, assertions=%0d failures=%0d", n_assert, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
